ysyx_23060077_riscv_axi_rd_arbiter: RTL and testbench
=====================================================

YSYX_23060077_RISCV_AXI_RD_ARBITER -- requirements
Module: ysyx_23060077_riscv_axi_rd_arbiter

Interface
REQ-001 SHALL have clock aclk, input, 1 bit; all logic on its rising edge.
REQ-002 SHALL have reset areset_n, input, 1 bit, synchronous, active-low.
REQ-003 SHALL have m0_ar_valid (1), m0_ar_addr (32) and m0_ar_port (3) as inputs: master 0 (IFU) read-address request.
REQ-004 SHALL have m0_ar_ready, output, 1: master 0 address accepted.
REQ-005 SHALL have m0_r_ready, input, 1: master 0 can take read data.
REQ-006 SHALL have m0_r_valid (1), m0_r_resp (2) and m0_r_data (32) as outputs: master 0 read-data channel.
REQ-007 SHALL have m1_* ports identical to REQ-003..006 for master 1 (LSU).
REQ-008 SHALL have s_ar_valid (1), s_ar_addr (32) and s_ar_port (3) as outputs, and s_ar_ready (1) as input: slave SRAM read-address channel.
REQ-009 SHALL have s_r_ready (1) as output, and s_r_valid (1), s_r_resp (2) and s_r_data (32) as inputs: slave read-data channel.

Function
REQ-010 SHALL implement FSM states IDLE, ADDR and DATA, with one outstanding slave transaction at most.
REQ-011 IDLE: if any mX_ar_valid=1, SHALL grant one master, latch its addr/port, pulse its mX_ar_ready=1 for exactly one cycle (registered), and go to ADDR.
REQ-012 ADDR: SHALL drive s_ar_valid=1 with the latched addr/port; on s_ar_valid&s_ar_ready it SHALL deassert s_ar_valid next cycle and go to DATA.
REQ-013 DATA: SHALL set s_r_ready = granted master's r_ready, and route s_r_valid/resp/data combinationally to the granted master only.
REQ-014 DATA: on s_r_valid&s_r_ready SHALL return to IDLE next cycle; a new grant is possible in that IDLE cycle.
REQ-015 The non-granted master SHALL see ar_ready=0, r_valid=0, r_data=0 and r_resp=0 at all times.
REQ-016 Minimum latency SHALL be: request at cycle N, mX_ar_ready and state ADDR at N+1, s_ar_valid high from N+1.
REQ-017 Requests arriving while not in IDLE SHALL be held by the master (valid stays high) and SHALL NOT be lost or double-granted.
REQ-018 Simultaneous requests SHALL be resolved per REQ-023/024; a single requester SHALL always win.
REQ-019 Latched addr/port SHALL stay stable from grant until the slave accepts the address, even if mX_ar_addr changes.

Reset
REQ-020 Under reset: state=IDLE; s_ar_valid, s_r_ready, all mX_ar_ready and mX_r_valid = 0; latched addr/port = 0; last_grant = m1.
REQ-021 Reset asserted mid-transaction SHALL abandon it silently: no r_valid is delivered afterwards for the abandoned request.

Configuration
REQ-022 Macro YSYX_23060077_ARB_RR_EN SHALL select the arbitration policy.
REQ-023 With the macro defined: round-robin, where on a tie the master not granted last (last_grant) wins, and last_grant updates on each grant.
REQ-024 With the macro undefined: fixed priority, where m1 (LSU) always wins a tie and last_grant is unused.

Verification
REQ-025 Single read: m0 requests addr 0x80000000; slave returns 0x00000413 -> m0_ar_ready pulses at N+1, m0_r_valid=1 with data 0x00000413, m1 outputs stay 0.
REQ-026 Tie under RR: m0 and m1 both request from reset -> m0 is served first, then m1; under fixed priority, m1 first, then m0.
REQ-027 Back-to-back m0 requests with m1 continuously requesting under RR -> grants alternate m0, m1, m0, m1.
REQ-028 Stalls: s_ar_ready delayed 3 cycles and m1_r_ready low for 2 cycles -> s_ar_addr stable throughout, s_r_ready=0 while m1_r_ready=0, data delivered once.
REQ-029 Reset in DATA state, then release -> all outputs 0, state IDLE, and the next m0 request completes normally.

Source files
------------

// File: rtl/ysyx_23060077_riscv_axi_rd_arbiter_if.sv
// AXI-lite style read channel bundle (AR + R) shared by the
// IFU, the LSU and the SRAM port of the read arbiter.
interface ysyx_23060077_riscv_axi_rd_arbiter_if;
    logic        ar_valid;
    logic [31:0] ar_addr;
    logic [2:0]  ar_port;
    logic        ar_ready;
    logic        r_ready;
    logic        r_valid;
    logic [1:0]  r_resp;
    logic [31:0] r_data;

    modport master (
        output ar_valid, ar_addr, ar_port, r_ready,
        input  ar_ready, r_valid, r_resp, r_data
    );

    modport slave (
        input  ar_valid, ar_addr, ar_port, r_ready,
        output ar_ready, r_valid, r_resp, r_data
    );
endinterface

// File: rtl/ysyx_23060077_riscv_axi_rd_arbiter.sv
// Two-master read arbiter (m0 = IFU, m1 = LSU) onto one SRAM port.
// YSYX_23060077_ARB_RR_EN selects round-robin, else fixed priority (m1).
module ysyx_23060077_riscv_axi_rd_arbiter (
    input  logic aclk,
    input  logic areset_n,
    ysyx_23060077_riscv_axi_rd_arbiter_if.slave  m0,
    ysyx_23060077_riscv_axi_rd_arbiter_if.slave  m1,
    ysyx_23060077_riscv_axi_rd_arbiter_if.master s
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic        r_grant;
    logic [31:0] r_addr;
    logic [2:0]  r_port;
    logic        r_m0_ar_ready;
    logic        r_m1_ar_ready;
    logic        w_any;
    logic        w_pick;
    logic        w_grant;
    logic        w_to_m0;
    logic        w_to_m1;
    logic        w_s_r_ready;

    assign w_any   = m0.ar_valid | m1.ar_valid;
    assign w_grant = (r_state == IDLE) & w_any;
    assign w_to_m0 = (r_state == DATA) & ~r_grant;
    assign w_to_m1 = (r_state == DATA) &  r_grant;

`ifdef YSYX_23060077_ARB_RR_EN
    logic r_last_grant;

    // Round-robin pick: on a tie the master not served last wins
    always_comb begin
        w_pick = m1.ar_valid;
        if (m0.ar_valid && m1.ar_valid) begin
            w_pick = ~r_last_grant;
        end
    end

    // Remember who was served most recently; m1 after reset
    always_ff @(posedge aclk) begin
        if (!areset_n) begin
            r_last_grant <= 1'b1;
        end else if (w_grant) begin
            r_last_grant <= w_pick;
        end
    end
`else
    // Fixed priority pick: the LSU wins any tie
    always_comb begin
        w_pick = m1.ar_valid;
    end
`endif

    // State register
    always_ff @(posedge aclk) begin
        if (!areset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic: one outstanding slave transaction at most
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE: begin
                if (w_any) begin
                    w_next = ADDR;
                end
            end
            ADDR: begin
                if (s.ar_ready) begin
                    w_next = DATA;
                end
            end
            DATA: begin
                if (s.r_valid && w_s_r_ready) begin
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    // Grant capture: latch winner and its request, pulse its ar_ready
    always_ff @(posedge aclk) begin
        if (!areset_n) begin
            r_grant       <= 1'b0;
            r_addr        <= 32'h0;
            r_port        <= 3'h0;
            r_m0_ar_ready <= 1'b0;
            r_m1_ar_ready <= 1'b0;
        end else begin
            r_m0_ar_ready <= 1'b0;
            r_m1_ar_ready <= 1'b0;
            if (w_grant) begin
                r_grant       <= w_pick;
                r_addr        <= w_pick ? m1.ar_addr : m0.ar_addr;
                r_port        <= w_pick ? m1.ar_port : m0.ar_port;
                r_m0_ar_ready <= ~w_pick;
                r_m1_ar_ready <= w_pick;
            end
        end
    end

    // Slave read-ready follows the granted master during DATA only
    always_comb begin
        w_s_r_ready = 1'b0;
        if (w_to_m0) begin
            w_s_r_ready = m0.r_ready;
        end else if (w_to_m1) begin
            w_s_r_ready = m1.r_ready;
        end
    end

    assign s.ar_valid = (r_state == ADDR);
    assign s.ar_addr  = r_addr;
    assign s.ar_port  = r_port;
    assign s.r_ready  = w_s_r_ready;

    assign m0.ar_ready = r_m0_ar_ready;
    assign m0.r_valid  = w_to_m0 & s.r_valid;
    assign m0.r_resp   = w_to_m0 ? s.r_resp : 2'b00;
    assign m0.r_data   = w_to_m0 ? s.r_data : 32'h0;

    assign m1.ar_ready = r_m1_ar_ready;
    assign m1.r_valid  = w_to_m1 & s.r_valid;
    assign m1.r_resp   = w_to_m1 ? s.r_resp : 2'b00;
    assign m1.r_data   = w_to_m1 ? s.r_data : 32'h0;

endmodule

// File: tb/tb_ysyx_23060077_riscv_axi_rd_arbiter.sv
// Bench for the two-master read arbiter: master/slave models,
// scoreboarded read data, table of grant-order vectors, corner sequences.
module tb_ysyx_23060077_riscv_axi_rd_arbiter;

    logic aclk = 1'b0;
    logic areset_n = 1'b0;

    always #5 aclk = ~aclk;

    ysyx_23060077_riscv_axi_rd_arbiter_if m0_if ();
    ysyx_23060077_riscv_axi_rd_arbiter_if m1_if ();
    ysyx_23060077_riscv_axi_rd_arbiter_if s_if ();

    ysyx_23060077_riscv_axi_rd_arbiter dut (
        .aclk     (aclk),
        .areset_n (areset_n),
        .m0       (m0_if),
        .m1       (m1_if),
        .s        (s_if)
    );

    typedef struct {
        int          n0;
        int          n1;
        logic [31:0] b0;
        logic [31:0] b1;
        int          dly;
        int          st1;
        int          len;
        logic [7:0]  rr;
        logic [7:0]  fp;
    } vec_t;

    vec_t vt [6];

    int n_tests = 0;
    int n_fail  = 0;
    int viol    = 0;
    int moved   = 0;
    int cyc     = 0;
    bit go      = 1'b0;
    int ar_delay = 0;
    int stall0  = 0;
    int stall1  = 0;
    bit drop0   = 1'b0;
    bit drop1   = 1'b0;
    int req_cyc0 = 0;
    int gnt_cyc0 = 0;
    logic sav0 = 1'b0;
    logic [31:0] last_d0 = 32'h0;
    logic [31:0] qa0 [$];
    logic [31:0] qa1 [$];
    logic [33:0] exp0 [$];
    logic [33:0] exp1 [$];
    int glog [$];

    // slave model state
    int sl_ph  = 0;
    int sl_cnt = 0;
    bit ar_fire;
    bit r_fire;
    logic [31:0] sl_hold = 32'h0;
    logic [2:0]  sl_port = 3'h0;
    bit sl_hold_v = 1'b0;

    function automatic logic [31:0] mem_rd(input logic [31:0] a,
                                           input logic [2:0] p);
        logic [31:0] d;
        d = (a == 32'h8000_0000) ? 32'h0000_0413 : (a ^ 32'hdead_beef);
        return d ^ {29'h0, p};
    endfunction

    function automatic logic [1:0] mem_rs(input logic [31:0] a);
        return a[3:2];
    endfunction

    task automatic check(input string nm, input logic [63:0] act,
                         input logic [63:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h", nm, act, req);
        end
    endtask

    // Slave: accepts AR after ar_delay cycles, answers one beat
    always begin
        @(negedge aclk);
        #2;
        ar_fire = s_if.ar_valid && s_if.ar_ready;
        r_fire  = s_if.r_valid && s_if.r_ready;
        @(posedge aclk);
        #1;
        if (!areset_n) begin
            s_if.ar_ready = 1'b0;
            s_if.r_valid  = 1'b0;
            s_if.r_data   = 32'h0;
            s_if.r_resp   = 2'b00;
            sl_ph = 0;
            sl_cnt = 0;
            sl_hold_v = 1'b0;
        end else if (sl_ph == 0) begin
            if (ar_fire) begin
                s_if.ar_ready = 1'b0;
                s_if.r_valid  = 1'b1;
                s_if.r_data   = mem_rd(sl_hold, sl_port);
                s_if.r_resp   = mem_rs(sl_hold);
                sl_ph = 1;
                sl_cnt = 0;
                sl_hold_v = 1'b0;
            end else if (s_if.ar_valid) begin
                if (sl_hold_v && s_if.ar_addr !== sl_hold) moved++;
                sl_hold = s_if.ar_addr;
                sl_port = s_if.ar_port;
                sl_hold_v = 1'b1;
                if (sl_cnt >= ar_delay) s_if.ar_ready = 1'b1;
                else sl_cnt++;
            end
        end else if (r_fire) begin
            s_if.r_valid = 1'b0;
            s_if.r_data  = 32'h0;
            s_if.r_resp  = 2'b00;
            sl_ph = 0;
        end
    end

    // Masters: issue queued requests, record grants, score read data
    always begin
        logic [33:0] e;
        @(negedge aclk);
        cyc++;
        if (!areset_n) begin
            m0_if.ar_valid = 1'b0;
            m0_if.ar_addr  = 32'h0;
            m0_if.ar_port  = 3'h0;
            m0_if.r_ready  = 1'b0;
            m1_if.ar_valid = 1'b0;
            m1_if.ar_addr  = 32'h0;
            m1_if.ar_port  = 3'h0;
            m1_if.r_ready  = 1'b0;
            drop0 = 1'b0;
            drop1 = 1'b0;
        end else if (go) begin
            if (drop0) begin
                m0_if.ar_valid = 1'b0;
                m0_if.ar_addr  = $urandom;
                drop0 = 1'b0;
            end
            if (!m0_if.ar_valid && qa0.size() > 0) begin
                m0_if.ar_valid = 1'b1;
                m0_if.ar_addr  = qa0.pop_front();
                m0_if.ar_port  = m0_if.ar_addr[6:4];
                req_cyc0 = cyc;
            end
            if (drop1) begin
                m1_if.ar_valid = 1'b0;
                m1_if.ar_addr  = $urandom;
                drop1 = 1'b0;
            end
            if (!m1_if.ar_valid && qa1.size() > 0) begin
                m1_if.ar_valid = 1'b1;
                m1_if.ar_addr  = qa1.pop_front();
                m1_if.ar_port  = m1_if.ar_addr[6:4];
            end
            m0_if.r_ready = (stall0 == 0);
            m1_if.r_ready = (stall1 == 0);
        end
        #2;
        if (areset_n) begin
            if (m0_if.ar_ready) begin
                drop0 = 1'b1;
                glog.push_back(0);
                gnt_cyc0 = cyc;
                sav0 = s_if.ar_valid;
                exp0.push_back({mem_rs(m0_if.ar_addr),
                                mem_rd(m0_if.ar_addr, m0_if.ar_port)});
            end
            if (m1_if.ar_ready) begin
                drop1 = 1'b1;
                glog.push_back(1);
                exp1.push_back({mem_rs(m1_if.ar_addr),
                                mem_rd(m1_if.ar_addr, m1_if.ar_port)});
            end
            if (m0_if.r_valid && m0_if.r_ready) begin
                if (exp0.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL m0 stray r_valid: got %h, want none",
                             m0_if.r_data);
                end else begin
                    e = exp0.pop_front();
                    check("m0 rdata", 64'({m0_if.r_resp, m0_if.r_data}),
                          64'(e));
                end
                last_d0 = m0_if.r_data;
            end
            if (m1_if.r_valid && m1_if.r_ready) begin
                if (exp1.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL m1 stray r_valid: got %h, want none",
                             m1_if.r_data);
                end else begin
                    e = exp1.pop_front();
                    check("m1 rdata", 64'({m1_if.r_resp, m1_if.r_data}),
                          64'(e));
                end
            end
            if (m0_if.r_valid && !m0_if.r_ready && stall0 > 0) stall0--;
            if (m1_if.r_valid && !m1_if.r_ready && stall1 > 0) stall1--;
            if (m0_if.r_valid && m1_if.r_valid) viol++;
            if (m0_if.ar_ready && m1_if.ar_ready) viol++;
            if (!m0_if.r_valid && (m0_if.r_data != 0 || m0_if.r_resp != 0))
                viol++;
            if (!m1_if.r_valid && (m1_if.r_data != 0 || m1_if.r_resp != 0))
                viol++;
            if (((m0_if.r_valid && !m0_if.r_ready) ||
                 (m1_if.r_valid && !m1_if.r_ready)) && s_if.r_ready)
                viol++;
        end
    end

    task automatic do_reset();
        go = 1'b0;
        areset_n = 1'b0;
        qa0.delete();
        qa1.delete();
        exp0.delete();
        exp1.delete();
        glog.delete();
        stall0 = 0;
        stall1 = 0;
        ar_delay = 0;
        repeat (2) @(posedge aclk);
        #1;
        areset_n = 1'b1;
    endtask

    task automatic wait_done(input int len, input logic [7:0] seq,
                             input string nm);
        int k;
        logic [7:0] g;
        k = 0;
        while (!(glog.size() >= len && qa0.size() == 0 &&
                 qa1.size() == 0 && exp0.size() == 0 &&
                 exp1.size() == 0) && k < 500) begin
            @(posedge aclk);
            k++;
        end
        check({nm, " done"}, 64'(k < 500), 64'(1));
        repeat (10) @(posedge aclk);
        #1;
        g = 8'h0;
        for (int i = 0; i < glog.size() && i < 8; i++) g[i] = glog[i][0];
        check({nm, " grants"}, 64'({24'(glog.size()), g}),
              64'({24'(len), seq}));
    endtask

    task automatic run_vec(input vec_t v, input string nm);
        logic [7:0] seq;
        do_reset();
        ar_delay = v.dly;
        stall1 = v.st1;
        for (int i = 0; i < v.n0; i++) qa0.push_back(v.b0 + 32'(i * 16));
        for (int i = 0; i < v.n1; i++) qa1.push_back(v.b1 + 32'(i * 16));
        @(posedge aclk);
        #1;
        go = 1'b1;
`ifdef YSYX_23060077_ARB_RR_EN
        seq = v.rr;
`else
        seq = v.fp;
`endif
        wait_done(v.len, seq, nm);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        logic seen;

        vt[0] = '{1, 0, 32'h8000_0024, 32'h0, 0, 0, 1, 8'h00, 8'h00};
        vt[1] = '{0, 1, 32'h0, 32'h8000_100c, 1, 0, 1, 8'h01, 8'h01};
        vt[2] = '{1, 1, 32'h8000_0000, 32'h8000_2004, 0, 0, 2,
                  8'b10, 8'b01};
        vt[3] = '{2, 2, 32'h8000_0100, 32'h8000_3008, 0, 0, 4,
                  8'b1010, 8'b0011};
        vt[4] = '{3, 3, 32'h8000_0200, 32'h8000_4000, 2, 0, 6,
                  8'b101010, 8'b000111};
        vt[5] = '{1, 2, 32'h8000_0300, 32'h8000_5004, 3, 2, 3,
                  8'b110, 8'b011};

        // reset state
        do_reset();
        #1;
        check("rst s_ar_valid", 64'(s_if.ar_valid), 64'(0));
        check("rst s_r_ready", 64'(s_if.r_ready), 64'(0));
        check("rst ar_ready", 64'({m0_if.ar_ready, m1_if.ar_ready}),
              64'(0));
        check("rst r_valid", 64'({m0_if.r_valid, m1_if.r_valid}), 64'(0));
        check("rst s_ar_addr", 64'(s_if.ar_addr), 64'(0));
        check("rst s_ar_port", 64'(s_if.ar_port), 64'(0));

        // single m0 read, minimum latency
        do_reset();
        qa0.push_back(32'h8000_0000);
        @(posedge aclk);
        #1;
        go = 1'b1;
        wait_done(1, 8'h00, "single");
        check("single latency", 64'(gnt_cyc0 - req_cyc0), 64'(1));
        check("single s_ar_valid", 64'(sav0), 64'(1));
        check("single data", 64'(last_d0), 64'(32'h0000_0413));

        for (int i = 0; i < 6; i++) run_vec(vt[i], $sformatf("vec%0d", i));

        // reset while in DATA abandons the read
        do_reset();
        stall0 = 1000;
        qa0.push_back(32'h8000_0044);
        @(posedge aclk);
        #1;
        go = 1'b1;
        k = 0;
        while (s_if.r_valid !== 1'b1 && k < 50) begin
            @(posedge aclk);
            #2;
            k++;
        end
        check("midrst in data", 64'(s_if.r_valid), 64'(1));
        check("midrst routed", 64'({m0_if.r_valid, s_if.r_ready,
                                    m1_if.r_valid}), 64'(3'b100));
        @(posedge aclk);
        #1;
        areset_n = 1'b0;
        go = 1'b0;
        repeat (2) @(posedge aclk);
        #2;
        check("midrst outs", 64'({s_if.ar_valid, s_if.r_ready,
                                  m0_if.ar_ready, m0_if.r_valid,
                                  m1_if.ar_ready, m1_if.r_valid}),
              64'(0));
        check("midrst addr", 64'(s_if.ar_addr), 64'(0));
        exp0.delete();
        glog.delete();
        qa0.delete();
        stall0 = 0;
        areset_n = 1'b1;
        @(posedge aclk);
        #1;
        go = 1'b1;
        seen = 1'b0;
        repeat (10) begin
            @(negedge aclk);
            #3;
            seen = seen | m0_if.r_valid;
        end
        check("midrst no stale", 64'(seen), 64'(0));
        qa0.push_back(32'h8000_0000);
        wait_done(1, 8'h00, "post-rst");
        check("post-rst latency", 64'(gnt_cyc0 - req_cyc0), 64'(1));
        check("post-rst data", 64'(last_d0), 64'(32'h0000_0413));

        check("isolation", 64'(viol), 64'(0));
        check("ar addr stable", 64'(moved), 64'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
